uart_tx: RTL

//   8N1/8x1 UART transmitter; transmit-side counterpart of the serial receiver.

---
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1/8x1 UART transmitter: 1-entry holding register feeding a serialiser, frames stream back to back.
// Optional parity bit after data bit 7 when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 20,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   tx_if,
  output logic       uart_txd_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic        StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ready_q;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end, frame_end, consume, load;

  assign bit_end   = (cnt_q == BitLast);
  assign frame_end = (state_q == STOP) && bit_end && (stop_q == StopLast);
  assign consume   = hold_full_q && ((state_q == IDLE) || frame_end);
  assign load      = tx_if.tx_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    txd_d       = 1'b1;

    // ready mirrors an empty holding register, so load and consume never coincide
    if (consume) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end else if (load) begin
      hold_d      = tx_if.tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == StopLast) begin
            state_d = hold_full_q ? START : IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so the flops change only on bit boundaries
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = (^shift_d) ^ PARITY_ODD[0];
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == BitLast) && (stop_d == StopLast);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign uart_txd_o     = txd_q;
  assign tx_busy_o      = busy_q;
  assign tx_done_o      = done_q;

endmodule
